// File: rtl/conv_layer_engine.sv
// Multi-channel 2-D convolution layer with optional ReLU and 2x2 max-pool.
// One signed multiply-accumulate per cycle, sequenced by a start/busy/done FSM.
module conv_layer_engine #(
  parameter int IMG_W  = 5,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int N_CH   = 2,
  parameter int W_BITS = 8,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [IMG_W*IMG_W*32-1:0]         image,
  input  logic [N_CH*K*K*W_BITS-1:0]        weights,
  output logic                              busy,
  output logic                              done,
  output logic [N_CH*OUT_W*OUT_W*32-1:0]    result
);

  localparam int POOL_W  = OUT_W / 2;
  localparam int ACC_W   = 32 + W_BITS + $clog2(K * K);
  localparam int N_WORDS = N_CH * OUT_W * OUT_W;
  localparam int N_POOL  = N_CH * POOL_W * POOL_W;
  localparam int CW      = $clog2(IMG_W + K + N_CH) + 1;

  localparam logic signed [ACC_W-1:0] SatMax = $signed({{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF});
  localparam logic signed [ACC_W-1:0] SatMin = $signed({{(ACC_W-32){1'b1}}, 32'h8000_0000});

  if ((IMG_W - K) % STRIDE != 0) begin : g_stride_chk
    $error("conv_layer_engine: (IMG_W-K) must be a multiple of STRIDE");
  end
  if (OUT_W < 2) begin : g_outw_chk
    $error("conv_layer_engine: OUT_W must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StWrite, StPool, StDone} state_e;

  state_e                       state_q, state_d;
  logic [IMG_W*IMG_W*32-1:0]    image_q;
  logic [N_CH*K*K*W_BITS-1:0]   weights_q;
  logic [1:0]                   mode_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic [CW-1:0]                kx_q, ky_q, ox_q, oy_q, ch_q;
  logic [N_WORDS*32-1:0]        buf_q;

  int unsigned                  pix_idx, w_idx, conv_idx, pool_base, pool_idx;
  logic signed [31:0]           pix;
  logic signed [W_BITS-1:0]     wt;
  logic signed [ACC_W-1:0]      prod;
  logic signed [31:0]           sat_val;
  logic signed [31:0]           p0, p1, p2, p3, pmax_a, pmax_b, pool_max;
  logic                         mac_last, pix_last, pool_last;

  // Address generation and arithmetic datapath
  always_comb begin
    pix_idx   = (STRIDE * 32'(oy_q) + 32'(ky_q)) * IMG_W + STRIDE * 32'(ox_q) + 32'(kx_q);
    w_idx     = 32'(ch_q) * K * K + 32'(ky_q) * K + 32'(kx_q);
    conv_idx  = 32'(ch_q) * OUT_W * OUT_W + 32'(oy_q) * OUT_W + 32'(ox_q);
    pool_base = 32'(ch_q) * OUT_W * OUT_W + 2 * 32'(oy_q) * OUT_W + 2 * 32'(ox_q);
    pool_idx  = 32'(ch_q) * POOL_W * POOL_W + 32'(oy_q) * POOL_W + 32'(ox_q);

    pix  = image_q[32*pix_idx +: 32];
    wt   = weights_q[W_BITS*w_idx +: W_BITS];
    prod = ACC_W'(pix) * ACC_W'(wt);

    if (acc_q > SatMax) begin
      sat_val = 32'h7FFF_FFFF;
    end else if (acc_q < SatMin) begin
      sat_val = 32'h8000_0000;
    end else begin
      sat_val = acc_q[31:0];
    end
    if (mode_q != 2'd0 && sat_val[31]) begin
      sat_val = '0;
    end

    p0       = buf_q[32*pool_base +: 32];
    p1       = buf_q[32*(pool_base + 1) +: 32];
    p2       = buf_q[32*(pool_base + OUT_W) +: 32];
    p3       = buf_q[32*(pool_base + OUT_W + 1) +: 32];
    pmax_a   = (p0 > p1) ? p0 : p1;
    pmax_b   = (p2 > p3) ? p2 : p3;
    pool_max = (pmax_a > pmax_b) ? pmax_a : pmax_b;

    mac_last  = (32'(kx_q) == K - 1) && (32'(ky_q) == K - 1);
    pix_last  = (32'(ox_q) == OUT_W - 1) && (32'(oy_q) == OUT_W - 1) && (32'(ch_q) == N_CH - 1);
    pool_last = (32'(ox_q) == POOL_W - 1) && (32'(oy_q) == POOL_W - 1) &&
                (32'(ch_q) == N_CH - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StMac;
      StMac:   if (mac_last) state_d = StWrite;
      StWrite: begin
        if (pix_last) begin
          state_d = (mode_q == 2'd2) ? StPool : StDone;
        end else begin
          state_d = StMac;
        end
      end
      StPool:  if (pool_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = buf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      image_q   <= '0;
      weights_q <= '0;
      mode_q    <= '0;
      acc_q     <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ch_q      <= '0;
      buf_q     <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          image_q   <= image;
          weights_q <= weights;
          mode_q    <= mode;
          acc_q     <= '0;
          kx_q      <= '0;
          ky_q      <= '0;
          ox_q      <= '0;
          oy_q      <= '0;
          ch_q      <= '0;
        end
        StMac: begin
          acc_q <= acc_q + prod;
          if (32'(kx_q) == K - 1) begin
            kx_q <= '0;
            ky_q <= mac_last ? '0 : ky_q + CW'(1);
          end else begin
            kx_q <= kx_q + CW'(1);
          end
        end
        StWrite: begin
          buf_q[32*conv_idx +: 32] <= sat_val;
          acc_q <= '0;
          if (32'(ox_q) == OUT_W - 1) begin
            ox_q <= '0;
            if (32'(oy_q) == OUT_W - 1) begin
              oy_q <= '0;
              ch_q <= pix_last ? '0 : ch_q + CW'(1);
            end else begin
              oy_q <= oy_q + CW'(1);
            end
          end else begin
            ox_q <= ox_q + CW'(1);
          end
        end
        StPool: begin
          // In-place is safe: each pooled word lands below every conv word still to be read.
          buf_q[32*pool_idx +: 32] <= pool_max;
          if (32'(ox_q) == POOL_W - 1) begin
            ox_q <= '0;
            if (32'(oy_q) == POOL_W - 1) begin
              oy_q <= '0;
              ch_q <= pool_last ? '0 : ch_q + CW'(1);
            end else begin
              oy_q <= oy_q + CW'(1);
            end
          end else begin
            ox_q <= ox_q + CW'(1);
          end
          if (pool_last) begin
            for (int i = N_POOL; i < N_WORDS; i++) begin
              buf_q[32*i +: 32] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Scoreboard bench for conv_layer_engine: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_conv_layer_engine;

  localparam int IMG_W  = 5;
  localparam int K      = 3;
  localparam int STRIDE = 2;
  localparam int N_CH   = 2;
  localparam int W_BITS = 8;
  localparam int OUT_W  = 2;
  localparam int NW     = N_CH * OUT_W * OUT_W;
  localparam int RW     = NW * 32;
  localparam int IW     = IMG_W * IMG_W * 32;
  localparam int WW     = N_CH * K * K * W_BITS;

  typedef struct packed {
    logic [RW-1:0] res;
    int            lat;
    int            done_cyc;
    int            id;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [IW-1:0] image;
  logic [WW-1:0] weights;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   busy_exp = 0;
  exp_t sb[$];

  conv_layer_engine #(
    .IMG_W  (IMG_W),
    .K      (K),
    .STRIDE (STRIDE),
    .N_CH   (N_CH),
    .W_BITS (W_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .image   (image),
    .weights (weights),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [RW-1:0] r;
    for (int i = 0; i < NW; i++) begin
      r[32*i +: 32] = (i == 0) ? a : ((i < 4) ? b : c);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] img_const(input logic [31:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < IMG_W * IMG_W; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [IW-1:0] img_ramp();
    logic [IW-1:0] r;
    for (int y = 0; y < IMG_W; y++) begin
      for (int x = 0; x < IMG_W; x++) r[32*(y*IMG_W+x) +: 32] = 32'(5 * y + x);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] wts(input logic [7:0] a, input logic [7:0] b);
    logic [WW-1:0] r;
    for (int i = 0; i < K * K; i++) begin
      r[8*i +: 8]         = a;
      r[8*(K*K+i) +: 8]   = b;
    end
    return r;
  endfunction

  // Monitor: compares every done pulse against the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy === 1'b1) begin
      busy_cnt++;
    end else begin
      if (busy_cnt != 0 && busy_exp != 0) chk("busy_len", RW'(busy_cnt), RW'(busy_exp));
      busy_cnt = 0;
      busy_exp = 0;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 exp no pending run at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < NW; i++) begin
          chk($sformatf("run%0d_word%0d", e.id, i), RW'(result[32*i +: 32]),
              RW'(e.res[32*i +: 32]));
        end
        chk($sformatf("run%0d_done_cycle", e.id), RW'(cyc), RW'(e.done_cyc));
        busy_exp = e.lat + 1;
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] m, input logic [RW-1:0] exp,
                       input int lat);
    exp_t e;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    e.res      = exp;
    e.lat      = lat;
    e.done_cyc = cyc + lat;
    e.id       = id;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL run_timeout got %0d cycles exp below %0d", n, budget);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   e1;
    exp_t e;
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'd0;
    image   = '0;
    weights = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", RW'(busy), RW'(0));
    chk("reset_done", RW'(done), RW'(0));
    chk("reset_result", result, '0);
    reset = 1'b0;

    // Plain conv and conv+ReLU
    image   = img_const(32'd1);
    weights = wts(8'd1, 8'hFF);
    issue(1, 2'd0, mk(32'd9, 32'd9, -32'sd9), 81);
    wait_idle(300);
    issue(2, 2'd1, mk(32'd9, 32'd9, 32'd0), 81);
    wait_idle(300);

    // Pool: ch0 conv = 6, 8, 16, 18
    image        = img_ramp();
    weights      = '0;
    weights[8*4 +: 8] = 8'd1;
    issue(3, 2'd2, mk(32'd18, 32'd0, 32'd0), 83);
    wait_idle(300);

    // Saturation both ways
    image   = img_const(32'h7FFF_FFFF);
    weights = wts(8'd127, 8'd127);
    issue(4, 2'd0, mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 81);
    wait_idle(300);
    weights = wts(8'h80, 8'h80);
    issue(5, 2'd0, mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000), 81);
    wait_idle(300);

    // Inputs and start toggled mid-run must not disturb the latched run
    image   = img_const(32'd1);
    weights = wts(8'd1, 8'hFF);
    issue(6, 2'd0, mk(32'd9, 32'd9, -32'sd9), 81);
    repeat (5) @(negedge clk);
    image   = img_const(32'd2);
    weights = wts(8'd3, 8'd3);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle(300);
    repeat (100) @(negedge clk);
    chk("no_second_run_busy", RW'(busy), RW'(0));

    // Reset 40 cycles into a run
    image   = img_const(32'd1);
    weights = wts(8'd1, 8'hFF);
    issue(7, 2'd2, mk(32'd9, 32'd0, 32'd0), 83);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_busy", RW'(busy), RW'(0));
    chk("midrun_reset_done", RW'(done), RW'(0));
    chk("midrun_reset_result", result, '0);
    sb.delete();
    reset = 1'b0;
    issue(8, 2'd1, mk(32'd9, 32'd9, 32'd0), 81);
    wait_idle(300);

    // start held high across two runs, mode switched during DONE
    @(negedge clk);
    mode  = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    e1         = cyc;
    e.res      = mk(32'd9, 32'd9, -32'sd9);
    e.lat      = 81;
    e.done_cyc = e1 + 81;
    e.id       = 9;
    sb.push_back(e);
    e.res      = mk(32'd9, 32'd0, 32'd0);
    e.lat      = 83;
    e.done_cyc = e1 + 83 + 83;
    e.id       = 10;
    sb.push_back(e);
    while (cyc < e1 + 81) @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    chk("held_idle_busy", RW'(busy), RW'(0));
    chk("held_idle_result", result, mk(32'd9, 32'd9, -32'sd9));
    @(negedge clk);
    chk("held_load_busy", RW'(busy), RW'(1));
    chk("held_load_result", result, mk(32'd9, 32'd9, -32'sd9));
    start = 1'b0;
    wait_idle(300);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

- Multi-channel 2-D convolution layer: one image in, `N_CH` output feature maps out.
- Successor to the standalone conv2d/relu/max_pool2d trio. It replaces them with one sequenced engine:
  - signed multi-bit weights instead of a 1-bit filter;
  - per-run mode selection: conv, conv+ReLU, or conv+ReLU+2×2 max-pool;
  - a start/busy/done handshake.
- Sits between the image memory and the next layer. Uses one multiply-accumulate, one tap per cycle.

## Interface

Parameters:

- `IMG_W`, default 5: input image width/height in pixels (square image).
- `K`, default 3: kernel width/height.
- `STRIDE`, default 2: convolution stride.
- `N_CH`, default 2: number of output channels (filters).
- `W_BITS`, default 8: signed weight width.
- Derived localparams:
  - `OUT_W = (IMG_W-K)/STRIDE+1`
  - `POOL_W = OUT_W/2`
  - `ACC_W = 32+W_BITS+$clog2(K*K)`
- Elaboration `$error` if `(IMG_W-K)%STRIDE != 0`.
- Elaboration `$error` if `OUT_W < 2`.

Ports:

- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request a run; sampled only in IDLE.
- `mode`, input, 2: 0 = conv, 1 = conv+ReLU, 2 = conv+ReLU+max-pool, 3 = reserved (behaves as 1).
- `image`, input, `IMG_W*IMG_W*32`: signed pixels; pixel (r,c) at `[32*(r*IMG_W+c) +: 32]`.
- `weights`, input, `N_CH*K*K*W_BITS`: signed taps; tap (ch,ky,kx) at `[W_BITS*(ch*K*K+ky*K+kx) +: W_BITS]`.
- `busy`, output, 1: high from LOAD through DONE inclusive.
- `done`, output, 1: one-cycle pulse when `result` is final.
- `result`, output, `N_CH*OUT_W*OUT_W*32`: signed output words; word i at `[32*i +: 32]`.

## Operation

State machine: IDLE → LOAD → MAC ⇄ WRITE → (POOL) → DONE → IDLE.

- **IDLE**
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE; `result` holds the previous run's values.
- **LOAD** (1 cycle)
  - Latch `image`, `weights` and `mode` into internal registers.
  - Clear the accumulator and all indices.
  - Inputs may change freely afterwards without affecting the run.
- **MAC** (K*K cycles per output pixel)
  - `acc += pix(STRIDE*oy+ky, STRIDE*ox+kx) * w(ch,ky,kx)`, full-precision signed `ACC_W`-bit arithmetic.
  - Inner loop kx, then ky.
  - After the last tap → WRITE.
- **WRITE** (1 cycle)
  - Saturate `acc` to 32-bit signed: >2^31−1 → 0x7FFFFFFF; <−2^31 → 0x80000000.
  - If mode ≠ 0, clamp negatives to 0.
  - Store to conv buffer word `ch*OUT_W*OUT_W + oy*OUT_W + ox`; clear `acc`.
  - Advance ox, then oy, then ch.
  - After the last pixel: → POOL if mode==2, else → DONE.
- **POOL** (1 cycle per pooled output, `N_CH*POOL_W*POOL_W` cycles)
  - Each output is the max of conv words (2py..2py+1, 2px..2px+1) for channel ch.
  - Written to word `ch*POOL_W*POOL_W + py*POOL_W + px`.
  - When `OUT_W` is odd, the trailing row/column is dropped.
  - All words at index ≥ `N_CH*POOL_W*POOL_W` are written 0.
- **DONE** (1 cycle)
  - `done`=1; `result` reflects the final buffer.
  - → IDLE.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, accumulator and indices 0.
- `start` is ignored whenever the state is not IDLE.
- Latency: if `start` is sampled at edge E, then `done`=1 during the cycle following edge E+L, where
  - `L = 1 + N_CH*OUT_W*OUT_W*(K*K+1) + P`
  - `P = N_CH*POOL_W*POOL_W` when mode==2, else 0.
  - With defaults: L = 81 (modes 0/1/3), L = 83 (mode 2).
- `busy` rises the cycle after the `start` sample and falls the cycle after `done`.
- `result` words may change while `busy`=1. They are valid from the `done` cycle and held until the next LOAD.
- `start` held high continuously: the next run's LOAD occurs 2 cycles after `done` (DONE → IDLE → LOAD).
- `reset` mid-run: at the next edge the engine returns to IDLE, `busy`=0, `done`=0, `result`=0, and no partial result remains. `reset` has priority over `start`.

## Test plan

1. Image all 1; ch0 weights all +1; ch1 weights all −1; mode 0 → words 0–3 = 9, words 4–7 = −9; `done` at L=81; `busy` high for exactly 82 cycles.
2. Same stimulus, mode 1 → words 0–3 = 9, words 4–7 = 0.
3. Image pixel(r,c)=5r+c; ch0 centre tap=1, others 0; ch1 all 0; mode 2:
   - internal conv values for ch0 are 6, 8, 16, 18;
   - result word0 = 18, word1 = 0, words 2–7 = 0; `done` at L=83.
4. Saturation, mode 0:
   - image all 0x7FFFFFFF with weights all 127 → every word = 0x7FFFFFFF;
   - same image with weights all −128 → every word = 0x80000000.
5. Change `image` and `weights` and pulse `start` while busy → result matches the values latched at LOAD, and no second run starts. Assert `reset` 40 cycles into a run → next cycle `busy`=0, `done`=0, `result`=0; a subsequent run completes correctly.
6. `start` held high across two runs with mode 0 then mode 2 (change `mode` during DONE) → second LOAD exactly 2 cycles after the first `done`; first result held until that LOAD; second `done` at L=83 after its start sample.
